// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of up to CDB_WIDTH FU writeback results per cycle onto registered CDB lanes.
module cdb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int CDB_WIDTH = 2,
  parameter int PRF_IDX   = 6,
  parameter int ROB_IDX   = 5,
  parameter int ARF_IDX   = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ROB_IDX-1:0]     req_rob_id,
  input  logic [NUM_REQ*ARF_IDX-1:0]     req_rd_arch,
  input  logic [NUM_REQ*PRF_IDX-1:0]     req_rd_phy,
  input  logic [NUM_REQ*32-1:0]          req_rd_value,
  output logic [CDB_WIDTH-1:0]           cdb_valid,
  output logic [CDB_WIDTH*ROB_IDX-1:0]   cdb_rob_id,
  output logic [CDB_WIDTH*ARF_IDX-1:0]   cdb_rd_arch,
  output logic [CDB_WIDTH*PRF_IDX-1:0]   cdb_rd_phy,
  output logic [CDB_WIDTH*32-1:0]        cdb_rd_value
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int LW = CDB_WIDTH > 1 ? $clog2(CDB_WIDTH) : 1;
  logic [PW-1:0] rr_ptr, nxt_ptr;
  logic [CDB_WIDTH-1:0] lane_use;
  logic [PW-1:0] lane_src [CDB_WIDTH];
  int cnt, idx;
  // Scan from rr_ptr with modulo wrap; the j-th winner lands on lane j.
  always_comb begin
    req_ready = '0;
    lane_use = '0;
    lane_src = '{default: '0};
    nxt_ptr = rr_ptr;
    cnt = 0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!rst && !flush && req_valid[PW'(idx)] && cnt < CDB_WIDTH) begin
        req_ready[PW'(idx)] = 1'b1;
        lane_use[LW'(cnt)] = 1'b1;
        lane_src[LW'(cnt)] = PW'(idx);
        nxt_ptr = PW'((idx + 1) % NUM_REQ);
        cnt = cnt + 1;
      end
    end
  end
  // Unused lanes keep their old payload; only the valid bit drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      cdb_valid <= '0;
      cdb_rob_id <= '0;
      cdb_rd_arch <= '0;
      cdb_rd_phy <= '0;
      cdb_rd_value <= '0;
    end else begin
      rr_ptr <= nxt_ptr;
      cdb_valid <= lane_use;
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (lane_use[k]) begin
          cdb_rob_id[k*ROB_IDX +: ROB_IDX] <= req_rob_id[int'(lane_src[k])*ROB_IDX +: ROB_IDX];
          cdb_rd_arch[k*ARF_IDX +: ARF_IDX] <= req_rd_arch[int'(lane_src[k])*ARF_IDX +: ARF_IDX];
          cdb_rd_phy[k*PRF_IDX +: PRF_IDX] <= req_rd_phy[int'(lane_src[k])*PRF_IDX +: PRF_IDX];
          cdb_rd_value[k*32 +: 32] <= req_rd_value[int'(lane_src[k])*32 +: 32];
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a queue-based round-robin model.
module tb_cdb_arbiter;
  localparam int NR = 3, CW = 2, PI = 6, RI = 5, AI = 5;
  logic clk = 0, rst = 1, flush = 0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [NR*RI-1:0] req_rob_id = '0;
  logic [NR*AI-1:0] req_rd_arch = '0;
  logic [NR*PI-1:0] req_rd_phy = '0;
  logic [NR*32-1:0] req_rd_value = '0;
  logic [CW-1:0] cdb_valid;
  logic [CW*RI-1:0] cdb_rob_id;
  logic [CW*AI-1:0] cdb_rd_arch;
  logic [CW*PI-1:0] cdb_rd_phy;
  logic [CW*32-1:0] cdb_rd_value;
  int m_ptr = 0;
  logic [CW-1:0] m_valid = '0;
  logic [CW*RI-1:0] m_rob = '0;
  logic [CW*AI-1:0] m_arch = '0;
  logic [CW*PI-1:0] m_phy = '0;
  logic [CW*32-1:0] m_val = '0;
  logic [NR-1:0] exp_ready;
  int g[$];
  int errors = 0, checks = 0;

  cdb_arbiter #(.NUM_REQ(NR), .CDB_WIDTH(CW), .PRF_IDX(PI), .ROB_IDX(RI), .ARF_IDX(AI)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_rob_id(req_rob_id), .req_rd_arch(req_rd_arch), .req_rd_phy(req_rd_phy), .req_rd_value(req_rd_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_rd_arch(cdb_rd_arch), .cdb_rd_phy(cdb_rd_phy),
    .cdb_rd_value(cdb_rd_value));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic new_payload(input int i);
    req_rob_id[i*RI +: RI] = RI'($urandom);
    req_rd_arch[i*AI +: AI] = AI'($urandom);
    req_rd_phy[i*PI +: PI] = PI'($urandom);
    req_rd_value[i*32 +: 32] = $urandom;
  endtask

  // Winners are the first CW valid requesters visited from m_ptr onward.
  task automatic predict();
    g.delete();
    exp_ready = '0;
    if (!rst && !flush)
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (req_valid[i] && g.size() < CW) begin
          g.push_back(i);
          exp_ready[i] = 1'b1;
        end
      end
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_valid = '0; m_rob = '0; m_arch = '0; m_phy = '0; m_val = '0;
    end else begin
      m_valid = '0;
      foreach (g[j]) begin
        m_valid[j] = 1'b1;
        m_rob[j*RI +: RI] = req_rob_id[g[j]*RI +: RI];
        m_arch[j*AI +: AI] = req_rd_arch[g[j]*AI +: AI];
        m_phy[j*PI +: PI] = req_rd_phy[g[j]*PI +: PI];
        m_val[j*32 +: 32] = req_rd_value[g[j]*32 +: 32];
      end
      if (g.size() > 0) m_ptr = (g[g.size()-1] + 1) % NR;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 3'b111;
    for (int i = 0; i < NR; i++) new_payload(i);
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    advance();
    rst = 0; req_valid = '0; #1;
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL reset_cdb_valid got=%b exp=00", cdb_valid); end
    checks++; if ({cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value} !== '0) begin errors++; $display("FAIL reset_payload got=%h exp=0", {cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value}); end
    advance();
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL reset_ptr_ready got=%b exp=011", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 3'b010;
    req_rob_id[RI +: RI] = 5'd3; req_rd_arch[AI +: AI] = 5'd7; req_rd_phy[PI +: PI] = 6'd5; req_rd_value[32 +: 32] = 32'hDEADBEEF;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    advance();
    req_valid = '0; #1;
    checks++; if (cdb_valid !== 2'b01) begin errors++; $display("FAIL single_valid got=%b exp=01", cdb_valid); end
    checks++; if ({cdb_rob_id[4:0], cdb_rd_arch[4:0], cdb_rd_phy[5:0], cdb_rd_value[31:0]} !== {5'd3, 5'd7, 6'd5, 32'hDEADBEEF})
      begin errors++; $display("FAIL single_lane0 got=%h exp=%h", {cdb_rob_id[4:0], cdb_rd_arch[4:0], cdb_rd_phy[5:0], cdb_rd_value[31:0]}, {5'd3, 5'd7, 6'd5, 32'hDEADBEEF}); end
    advance();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] tbl [3];
    tbl = '{3'b011, 3'b101, 3'b110};
    req_valid = 3'b100; new_payload(2); #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rr_setup_ready got=%b exp=100", req_ready); end
    advance();
    req_valid = 3'b111;
    for (int i = 0; i < NR; i++) new_payload(i);
    for (int c = 0; c < 3; c++) begin
      #1; predict();
      checks++; if (req_ready !== tbl[c]) begin errors++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, tbl[c]); end
      checks++; if ({cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value} !== {m_valid, m_rob, m_arch, m_phy, m_val})
        begin errors++; $display("FAIL rr_cdb c=%0d got=%h exp=%h", c, {cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value}, {m_valid, m_rob, m_arch, m_phy, m_val}); end
      advance();
      for (int i = 0; i < NR; i++) if (tbl[c][i]) new_payload(i);
    end
    req_valid = '0; #1;
    checks++; if ({cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value} !== {m_valid, m_rob, m_arch, m_phy, m_val})
      begin errors++; $display("FAIL rr_cdb_last got=%h exp=%h", {cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value}, {m_valid, m_rob, m_arch, m_phy, m_val}); end
    advance();
  endtask

  task automatic test_flush();
    req_valid = 3'b111; flush = 1; #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
    advance();
    flush = 0; req_valid = '0; #1;
    checks++; if (cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_cdb_valid got=%b exp=00", cdb_valid); end
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL flush_ptr_ready got=%b exp=011", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    req_valid = 3'b011; new_payload(0); new_payload(1); #1;
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL rstmid_ready got=%b exp=011", req_ready); end
    advance();
    req_valid = '0; rst = 1;
    advance();
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if ({cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value} !== '0)
        begin errors++; $display("FAIL rstmid_cdb c=%0d got=%h exp=0", c, {cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value}); end
      advance();
    end
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL rstmid_ptr_ready got=%b exp=011", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_idle();
    req_valid = 3'b001; new_payload(0); #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL idle_setup_ready got=%b exp=001", req_ready); end
    advance();
    req_valid = '0;
    advance();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (cdb_valid !== 2'b00 || req_ready !== 3'b000) begin errors++; $display("FAIL idle_quiet c=%0d got=%b/%b exp=00/000", c, cdb_valid, req_ready); end
      advance();
    end
    req_valid = 3'b100; new_payload(2); #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL idle_ready got=%b exp=100", req_ready); end
    advance();
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b011) begin errors++; $display("FAIL idle_ptr_ready got=%b exp=011", req_ready); end
    req_valid = '0;
    advance();
  endtask

  task automatic test_random();
    logic [NR-1:0] last_rdy;
    last_rdy = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!(req_valid[i] && !last_rdy[i])) begin
          req_valid[i] = $urandom_range(0, 3) != 0;
          new_payload(i);
        end
      flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 49) == 0;
      #1; predict();
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      checks++; if ({cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value} !== {m_valid, m_rob, m_arch, m_phy, m_val})
        begin errors++; $display("FAIL rand_cdb c=%0d got=%h exp=%h", c, {cdb_valid, cdb_rob_id, cdb_rd_arch, cdb_rd_phy, cdb_rd_value}, {m_valid, m_rob, m_arch, m_phy, m_val}); end
      last_rdy = exp_ready;
      advance();
    end
    rst = 0; flush = 0; req_valid = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_flush();
    test_reset_mid();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the CDB_WIDTH common-data-bus lanes among NUM_REQ functional-unit writeback ports (ALU(s), MD unit, later LSU).
- Each FU presents a completed result with a valid/ready handshake.
- Arbiter grants up to CDB_WIDTH requesters per cycle in round-robin order and drives registered CDB lanes.
- CDB lanes feed PRF write, RS wakeup, RAT and ROB completion.

Parameters:
- NUM_REQ, 3, number of FU writeback requesters.
- CDB_WIDTH, 2, number of CDB lanes (cpu_params::CDB_WIDTH).
- PRF_IDX, 6, physical register index width.
- ROB_IDX, 5, ROB index width.
- ARF_IDX, 5, architectural register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (branch mispredict); drops in-flight and new grants
- req_valid  in  NUM_REQ  FU i has a result
- req_ready  out  NUM_REQ  FU i granted this cycle; transfer = valid & ready
- req_rob_id  in  NUM_REQ*ROB_IDX  ROB id per requester, requester i at [i*ROB_IDX +: ROB_IDX]
- req_rd_arch  in  NUM_REQ*ARF_IDX  arch dest per requester
- req_rd_phy  in  NUM_REQ*PRF_IDX  phys dest per requester
- req_rd_value  in  NUM_REQ*32  result value per requester
- cdb_valid  out  CDB_WIDTH  lane k carries a result
- cdb_rob_id  out  CDB_WIDTH*ROB_IDX  lane ROB id
- cdb_rd_arch  out  CDB_WIDTH*ARF_IDX  lane arch dest
- cdb_rd_phy  out  CDB_WIDTH*PRF_IDX  lane phys dest
- cdb_rd_value  out  CDB_WIDTH*32  lane value

Behaviour:
- State:
  - rr_ptr, $clog2(NUM_REQ) bits: highest-priority requester.
  - Registered lane bank: valid, rob_id, rd_arch, rd_phy, rd_value per lane.
- Reset (rst=1 at posedge):
  - rr_ptr=0.
  - All cdb_valid=0; all lane payload regs=0.
  - req_ready is combinational and 0 while rst=1.
- Grant selection (combinational, same cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first CDB_WIDTH requesters with req_valid=1 get req_ready=1.
  - The j-th granted requester in scan order maps to lane j.
  - Ungranted requesters: req_ready=0.
  - req_ready may depend on req_valid; it never depends on other outputs.
- Requester rules:
  - Requester must hold valid and payload stable until ready.
  - Arbiter never grants a requester with valid=0.
- Latency:
  - Granted payload appears on its lane exactly 1 cycle after the handshake.
  - Lanes not assigned in a cycle have cdb_valid=0 next cycle; payload is don't-care but held at its previous value.
  - No internal buffering beyond the lane registers; full throughput of CDB_WIDTH results/cycle.
- rr_ptr update:
  - If at least one grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - If no grant: rr_ptr unchanged.
  - Guarantees no requester waits more than ceil(NUM_REQ/CDB_WIDTH) grant cycles.
- Wrap-around:
  - Scan and pointer arithmetic are modulo NUM_REQ (NUM_REQ need not be a power of 2).
  - rr_ptr must never hold a value >= NUM_REQ.
- rd_arch==0 results are forwarded unchanged with cdb_valid=1; ROB needs completion, and PRF/RAT consumers ignore x0.
- flush=1:
  - All req_ready=0 that cycle.
  - Next cycle all cdb_valid=0.
  - rr_ptr unchanged.
- Simultaneous events:
  - rst dominates flush.
  - flush dominates grants.
- Reset mid-operation: in-flight lane contents are discarded; no result from before rst appears after it.
- If NUM_REQ <= CDB_WIDTH, every valid requester is granted every cycle.

Test Plan (NUM_REQ=3, CDB_WIDTH=2):
1. Assert rst with req_valid=3'b111 -> req_ready=000. Cycle after release with no requests: cdb_valid=00, rr_ptr=0.
2. Cycle N: req_valid=3'b010, rob_id=3, rd_arch=7, rd_phy=5, value=32'hDEADBEEF -> req_ready=010. Cycle N+1: cdb_valid=01, lane0 = {3,7,5,DEADBEEF}; rr_ptr=2.
3. req_valid=111 held, rr_ptr=0:
   - C0: ready=011 (req0->lane0, req1->lane1), rr_ptr->2.
   - C1: ready=101 (req2->lane0, req0->lane1), rr_ptr->1.
   - C2: ready=110 (req1->lane0, req2->lane1).
   - Each result appears once, 1 cycle after its grant.
4. req_valid=111 with flush=1 -> req_ready=000. Next cycle cdb_valid=00; rr_ptr unchanged.
5. Grant to req0 and req1 in cycle N, rst=1 in cycle N+1 -> cycle N+2: cdb_valid=00, rr_ptr=0; the req0/req1 results never reappear.
6. req_valid=000 for 5 cycles after rr_ptr=1 -> cdb_valid=00 each cycle, rr_ptr stays 1. Then req_valid=100 -> ready=100, rr_ptr->0.
